// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: widths, ALU opcodes and the EX-stage control bundle.
package cpu_types_pkg;

    localparam int unsigned CPU_DATA_W  = 32;
    localparam int unsigned CPU_REG_AW  = 5;
    localparam int unsigned CPU_ALUOP_W = 4;

    typedef logic [CPU_REG_AW-1:0] regbits_t;
    typedef logic [CPU_DATA_W-1:0] word_t;

    typedef enum logic [CPU_ALUOP_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_NOR    = 4'd5,
        ALU_SLT    = 4'd6,
        ALU_SLTU   = 4'd7,
        ALU_SLL    = 4'd8,
        ALU_SRL    = 4'd9,
        ALU_SRA    = 4'd10,
        ALU_LUI    = 4'd11,
        ALU_PASS_A = 4'd12,
        ALU_PASS_B = 4'd13,
        ALU_MUL    = 4'd14,
        ALU_NOP    = 4'd15
    } aluop_t;

    typedef struct packed {
        logic   valid;
        logic   memread;
        logic   memwrite;
        logic   regwrite;
        aluop_t aluop;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = ex_ctrl_t'('0);

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the EX slot holds a load whose non-$0 destination
// is read by the instruction currently in decode.
module load_use_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    output logic              hz_c
);

    logic rd_nonzero;
    logic rs_match;
    logic rt_match;

    assign rd_nonzero = (ex_rd != '0);
    assign rs_match   = (ex_rd == id_rs);
    assign rt_match   = id_uses_rt & (ex_rd == id_rt);

    assign hz_c = ex_valid & ex_memread & rd_nonzero & id_valid & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, freeze and flush.
// Optional bubble counter output enabled by defining ID_EX_PERF_EN.
module id_ex_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               freeze,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic               id_uses_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic [DATA_W-1:0]  id_rdat1,
    input  logic [DATA_W-1:0]  id_rdat2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               id_regwrite,
    output logic               id_stall,
    output logic               ex_valid,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [DATA_W-1:0]  ex_rdat1,
    output logic [DATA_W-1:0]  ex_rdat2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic               ex_regwrite
`ifdef ID_EX_PERF_EN
    ,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    ex_ctrl_t          ctrl_q, ctrl_d;
    ex_ctrl_t          id_ctrl;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] rdat1_q, rdat1_d;
    logic [DATA_W-1:0] rdat2_q, rdat2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              hz_c;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_valid   (ctrl_q.valid),
        .ex_memread (ctrl_q.memread),
        .ex_rd      (rd_q),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .hz_c       (hz_c)
    );

    // Flush squashes the decode slot and freeze already holds upstream, so neither stalls.
    assign id_stall = hz_c & ~flush & ~freeze;

    always_comb begin
        id_ctrl.valid    = id_valid;
        id_ctrl.memread  = id_memread;
        id_ctrl.memwrite = id_memwrite;
        id_ctrl.regwrite = id_regwrite;
        id_ctrl.aluop    = aluop_t'(CPU_ALUOP_W'(id_aluop));
    end

    // Next-state selection: freeze > flush/hazard bubble > load from decode.
    always_comb begin
        ctrl_d  = ctrl_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        rdat1_d = rdat1_q;
        rdat2_d = rdat2_q;
        imm_d   = imm_q;
        if (!freeze) begin
            if (flush || hz_c) begin
                ctrl_d  = BUBBLE_CTRL;
                rs_d    = '0;
                rt_d    = '0;
                rd_d    = '0;
                rdat1_d = '0;
                rdat2_d = '0;
                imm_d   = '0;
            end else begin
                rdat1_d = id_rdat1;
                rdat2_d = id_rdat2;
                imm_d   = id_imm;
                if (id_valid) begin
                    ctrl_d = id_ctrl;
                    rs_d   = id_rs;
                    rt_d   = id_rt;
                    rd_d   = id_rd;
                end else begin
                    ctrl_d = BUBBLE_CTRL;
                    rs_d   = '0;
                    rt_d   = '0;
                    rd_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl_q  <= BUBBLE_CTRL;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            rdat1_q <= '0;
            rdat2_q <= '0;
            imm_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            rdat1_q <= rdat1_d;
            rdat2_q <= rdat2_d;
            imm_q   <= imm_d;
        end
    end

    assign ex_valid    = ctrl_q.valid;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_aluop    = ALUOP_W'(ctrl_q.aluop);
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;
    assign ex_rdat1    = rdat1_q;
    assign ex_rdat2    = rdat2_q;
    assign ex_imm      = imm_q;

`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count only interlock bubbles; saturate rather than wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (id_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage; define ID_EX_PERF_EN to also check bubble_cnt.
module tb_id_ex_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned OW = 4;
    localparam int unsigned CW = 2;
    localparam int          NROWS = 23;

    logic          CLK, RST, freeze, flush, id_valid, id_uses_rt;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rdat1, id_rdat2, id_imm;
    logic [OW-1:0] id_aluop;
    logic          id_memread, id_memwrite, id_regwrite;
    logic          id_stall, ex_valid, ex_memread, ex_memwrite, ex_regwrite;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_rdat1, ex_rdat2, ex_imm;
    logic [OW-1:0] ex_aluop;
`ifdef ID_EX_PERF_EN
    logic [CW-1:0] bubble_cnt;
`endif

    id_ex_stage #(
        .DATA_W (DW), .REG_AW (AW), .ALUOP_W (OW), .CNT_W (CW)
    ) dut (
        .CLK (CLK), .RST (RST), .freeze (freeze), .flush (flush),
        .id_valid (id_valid), .id_rs (id_rs), .id_rt (id_rt), .id_uses_rt (id_uses_rt),
        .id_rd (id_rd), .id_rdat1 (id_rdat1), .id_rdat2 (id_rdat2), .id_imm (id_imm),
        .id_aluop (id_aluop), .id_memread (id_memread), .id_memwrite (id_memwrite),
        .id_regwrite (id_regwrite), .id_stall (id_stall), .ex_valid (ex_valid),
        .ex_rs (ex_rs), .ex_rt (ex_rt), .ex_rd (ex_rd), .ex_rdat1 (ex_rdat1),
        .ex_rdat2 (ex_rdat2), .ex_imm (ex_imm), .ex_aluop (ex_aluop),
        .ex_memread (ex_memread), .ex_memwrite (ex_memwrite), .ex_regwrite (ex_regwrite)
`ifdef ID_EX_PERF_EN
        , .bubble_cnt (bubble_cnt)
`endif
    );

    typedef struct packed {
        logic          frz, fl, v, ut;
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] d1, d2, imm;
        logic [OW-1:0] op;
        logic          mr, mw, rw;
        logic          e_stall, e_valid;
        logic [AW-1:0] e_rd;
    } vec_t;

    typedef struct packed {
        logic          valid, mr, mw, rw;
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] d1, d2, imm;
        logic [OW-1:0] op;
    } ex_t;

    vec_t tbl [NROWS];
    ex_t  sbq [$];
    ex_t  m;
    int   nrow;
    int   checks;
    int   errors;
    int   mcnt;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic frz, input logic fl, input logic v,
                       input int rs, input int rt, input logic ut, input int rd,
                       input logic mr, input logic mw, input logic rw, input int op,
                       input logic e_stall, input logic e_valid, input int e_rd);
        vec_t r;
        r.frz = frz; r.fl = fl; r.v = v; r.ut = ut;
        r.rs = AW'(rs); r.rt = AW'(rt); r.rd = AW'(rd);
        r.d1 = 32'hA000_0000 + DW'(nrow);
        r.d2 = 32'hB000_0000 + DW'(nrow);
        r.imm = 32'h0000_C000 + DW'(nrow);
        r.op = OW'(op);
        r.mr = mr; r.mw = mw; r.rw = rw;
        r.e_stall = e_stall; r.e_valid = e_valid; r.e_rd = AW'(e_rd);
        tbl[nrow] = r;
        nrow++;
    endtask

    function automatic logic model_hz(input ex_t s, input vec_t v);
        return s.valid & s.mr & (s.rd != '0) & v.v &
               ((s.rd == v.rs) | (v.ut & (s.rd == v.rt)));
    endfunction

    function automatic ex_t model_next(input ex_t s, input vec_t v);
        ex_t n;
        n = '0;
        if (v.frz) return s;
        if (v.fl || model_hz(s, v)) return n;
        n.d1 = v.d1; n.d2 = v.d2; n.imm = v.imm;
        n.valid = v.v;
        if (v.v) begin
            n.mr = v.mr; n.mw = v.mw; n.rw = v.rw;
            n.rs = v.rs; n.rt = v.rt; n.rd = v.rd; n.op = v.op;
        end
        return n;
    endfunction

    task automatic drive(input vec_t v);
        freeze = v.frz; flush = v.fl; id_valid = v.v; id_uses_rt = v.ut;
        id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
        id_rdat1 = v.d1; id_rdat2 = v.d2; id_imm = v.imm; id_aluop = v.op;
        id_memread = v.mr; id_memwrite = v.mw; id_regwrite = v.rw;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 0);
        chk({tag, "_rd"}, 32'(ex_rd), 0);
        chk({tag, "_rs"}, 32'(ex_rs), 0);
        chk({tag, "_rt"}, 32'(ex_rt), 0);
        chk({tag, "_ctrl"}, 32'({ex_memread, ex_memwrite, ex_regwrite}), 0);
        chk({tag, "_data"}, ex_rdat1 | ex_rdat2 | ex_imm | 32'(ex_aluop), 0);
        chk({tag, "_stall"}, 32'(id_stall), 0);
    endtask

    initial begin
        ex_t  e;
        vec_t idle;
        checks = 0; errors = 0; nrow = 0; mcnt = 0; m = '0;
        idle = '0;
        RST = 1'b1;
        drive(idle);
        #1;
        check_zero("reset");
`ifdef ID_EX_PERF_EN
        chk("reset_cnt", 32'(bubble_cnt), 0);
`endif

        //  frz fl v  rs rt ut rd mr mw rw op  stall valid rd
        add(0, 0, 1,  1, 2, 0,  8, 1, 0, 1, 0,  0, 1,  8);   // load $8
        add(0, 0, 1,  8, 3, 0, 10, 0, 0, 1, 2,  1, 0,  0);   // consumer rs=8: bubble
        add(0, 0, 1,  8, 3, 0, 10, 0, 0, 1, 2,  0, 1, 10);   // consumer advances
        add(0, 0, 1,  0, 0, 0,  9, 1, 0, 1, 0,  0, 1,  9);   // load $9
        add(0, 0, 1,  5, 9, 0, 11, 0, 0, 1, 3,  0, 1, 11);   // rt=9 but unused: no stall
        add(0, 0, 1,  0, 0, 0,  9, 1, 0, 1, 0,  0, 1,  9);   // load $9 again
        add(0, 0, 1,  5, 9, 1,  0, 0, 1, 0, 0,  1, 0,  0);   // store uses rt=9: bubble
        add(0, 0, 1,  5, 9, 1,  0, 0, 1, 0, 0,  0, 1,  0);   // store advances
        add(0, 0, 1,  0, 0, 0,  0, 1, 0, 1, 0,  0, 1,  0);   // load to $0
        add(0, 0, 1,  0, 0, 0, 12, 0, 0, 1, 4,  0, 1, 12);   // rs=0: never stalls
        add(0, 0, 1,  0, 0, 0,  4, 1, 0, 1, 0,  0, 1,  4);   // load $4
        add(0, 1, 1,  4, 0, 0, 13, 0, 0, 1, 5,  0, 0,  0);   // flush+hz: bubble, no stall
        add(0, 0, 1,  1, 0, 0,  6, 1, 0, 1, 0,  0, 1,  6);   // load $6
        add(1, 0, 1,  6, 0, 0, 14, 0, 0, 1, 6,  0, 1,  6);   // freeze+hz: hold
        add(1, 0, 1,  6, 0, 0, 14, 0, 0, 1, 6,  0, 1,  6);
        add(1, 0, 1,  6, 0, 0, 14, 0, 0, 1, 6,  0, 1,  6);
        add(0, 0, 1,  6, 0, 0, 14, 0, 0, 1, 6,  1, 0,  0);   // hz re-evaluated after freeze
        add(0, 0, 1,  6, 0, 0, 14, 0, 0, 1, 6,  0, 1, 14);
        add(0, 0, 0, 14, 0, 0, 15, 1, 1, 1, 7,  0, 0,  0);   // invalid id: forced bubble
        add(0, 0, 1,  0, 0, 0,  1, 0, 0, 1, 8,  0, 1,  1);
        add(0, 0, 1,  0, 0, 0,  2, 1, 0, 1, 0,  0, 1,  2);   // load $2
        add(0, 0, 1,  2, 0, 0, 16, 0, 0, 1, 9,  1, 0,  0);   // fourth interlock bubble
        add(0, 0, 1,  2, 0, 0, 16, 0, 0, 1, 9,  0, 1, 16);

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < nrow; i++) begin
            logic mstall;
            @(negedge CLK);
            drive(tbl[i]);
            #1;
            mstall = model_hz(m, tbl[i]) & ~tbl[i].fl & ~tbl[i].frz;
            chk($sformatf("row%0d_stall", i), 32'(id_stall), 32'(tbl[i].e_stall));
            if (mstall && mcnt != (1 << CW) - 1) mcnt++;
            m = model_next(m, tbl[i]);
            sbq.push_back(m);
            @(posedge CLK);
            #1;
            if (sbq.size() == 0) begin
                chk($sformatf("row%0d_sbq_empty", i), 0, 1);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("row%0d_valid_tbl", i), 32'(ex_valid), 32'(tbl[i].e_valid));
                chk($sformatf("row%0d_rd_tbl", i), 32'(ex_rd), 32'(tbl[i].e_rd));
                chk($sformatf("row%0d_valid", i), 32'(ex_valid), 32'(e.valid));
                chk($sformatf("row%0d_ctrl", i), 32'({ex_memread, ex_memwrite, ex_regwrite}),
                    32'({e.mr, e.mw, e.rw}));
                chk($sformatf("row%0d_idx", i), 32'({ex_rs, ex_rt, ex_rd}), 32'({e.rs, e.rt, e.rd}));
                if (e.valid) begin
                    chk($sformatf("row%0d_rdat1", i), ex_rdat1, e.d1);
                    chk($sformatf("row%0d_rdat2", i), ex_rdat2, e.d2);
                    chk($sformatf("row%0d_imm", i), ex_imm, e.imm);
                    chk($sformatf("row%0d_aluop", i), 32'(ex_aluop), 32'(e.op));
                end
`ifdef ID_EX_PERF_EN
                chk($sformatf("row%0d_cnt", i), 32'(bubble_cnt), 32'(mcnt));
                if (i == 19) chk("cnt_after_3_events", 32'(bubble_cnt), 3);
`endif
            end
        end
`ifdef ID_EX_PERF_EN
        chk("cnt_saturated", 32'(bubble_cnt), 3);
`endif

        // Asynchronous reset mid-run with a load $7 in EX and a dependent in decode.
        @(negedge CLK);
        idle = '0;
        idle.v = 1'b1; idle.rd = AW'(7); idle.mr = 1'b1; idle.rw = 1'b1;
        drive(idle);
        @(posedge CLK);
        #1;
        idle.rd = AW'(3); idle.rs = AW'(7); idle.mr = 1'b0;
        drive(idle);
        #1;
        chk("pre_reset_valid", 32'(ex_valid), 1);
        chk("pre_reset_rd", 32'(ex_rd), 7);
        chk("pre_reset_stall", 32'(id_stall), 1);
        #1;
        RST = 1'b1;
        #1;
        check_zero("async_reset");
`ifdef ID_EX_PERF_EN
        chk("async_reset_cnt", 32'(bubble_cnt), 0);
`endif
        @(negedge CLK);
        RST = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with a built-in load-use interlock; sits directly upstream of the EX-stage forwarding logic.
- Latches decoded operands and control each cycle.
- Presents ex_rs/ex_rt/ex_rd to the forwarding logic and EX datapath.
- Detects a load-use hazard, stalls IF/ID and injects a one-cycle bubble.
- Honours a global freeze (memory wait) and a flush (taken branch/jump).

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register-index width
ALUOP_W, 4, ALU opcode width
CNT_W, 16, bubble-counter width (optional feature only)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
freeze  in  1  global hold (dmem/imem wait); all state holds
flush  in  1  taken branch/jump; squash the incoming ID instruction
id_valid  in  1  decode slot holds a real instruction
id_rs  in  REG_AW  source register A
id_rt  in  REG_AW  source register B
id_uses_rt  in  1  instruction reads rt as a source
id_rd  in  REG_AW  destination register
id_rdat1  in  DATA_W  register-file port A data
id_rdat2  in  DATA_W  register-file port B data
id_imm  in  DATA_W  extended immediate
id_aluop  in  ALUOP_W  ALU operation
id_memread  in  1  load
id_memwrite  in  1  store
id_regwrite  in  1  writes rd
id_stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX slot valid
ex_rs, ex_rt, ex_rd  out  REG_AW  registered indices
ex_rdat1, ex_rdat2, ex_imm  out  DATA_W  registered data
ex_aluop  out  ALUOP_W  registered ALU op
ex_memread, ex_memwrite, ex_regwrite  out  1  registered control

Behaviour:
- Reset (async, RST=1): every ex_* output = 0; bubble counter = 0. id_stall is combinational and therefore reads 0 while all ex_* are 0.
- Hazard (combinational): hz = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
- id_stall = hz & ~flush & ~freeze.
- Per-edge priority, highest first:
  - freeze=1: all ex_* hold.
  - flush=1: load bubble.
  - hz=1: load bubble; ID instruction remains in IF/ID because id_stall=1.
  - otherwise: load all id_* fields; ex_valid <= id_valid.
- Bubble: ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_rd, ex_rs, ex_rt <= 0; data and aluop fields are don't-care and implemented as 0.
- A loaded instruction with id_valid=0 behaves as a bubble: all control bits and indices are forced to 0.
- Latency: one cycle ID->EX. A load-use hazard costs exactly one bubble. After the bubble, ex_memread=0, so hz clears and the consumer advances the next cycle, taking the load value from MEM/WB forwarding.
- Load followed by store using rt: hazard applies (id_uses_rt=1).
- Destination $0 never triggers a stall.
- flush and hz in the same cycle: flush wins and id_stall=0, so the squashed instruction is not held.
- freeze and hz in the same cycle: id_stall=0 because the global freeze already holds upstream; hz re-evaluates after freeze drops.
- No further state: no FSM beyond the registers.

Optional Feature:
ID_EX_PERF_EN
- Defined: adds output bubble_cnt[CNT_W]. It increments on each edge where a hz bubble is inserted (not flush, not freeze), saturates at all-ones, and resets to 0 on RST.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_types_pkg holds:
  - aluop_t enum
  - regbits_t (REG_AW)
  - word_t (DATA_W)
  - ex_ctrl_t packed struct {valid, memread, memwrite, regwrite, aluop}
  - BUBBLE_CTRL constant (all zero)
- Natural sub-module: load_use_detect, a pure combinational hz computation, reusable by a later hazard unit.
- Register bank stays in id_ex_stage.

Test Plan:
1. Reset mid-run: assert RST with ex_valid=1 and ex_rd=7 -> all ex_* become 0 immediately, without waiting for a clock edge; id_stall=0.
2. Load-use: cycle N loads to $8 (ex_memread=1, ex_rd=8); ID has rs=8 -> id_stall=1 at N; at N+1 ex_valid=0 and id_stall=0; at N+2 ex_rs=8 with the consumer's data.
3. rt-only dependency: ex load rd=9; ID rt=9 with id_uses_rt=0 -> no stall. Same with id_uses_rt=1 -> one bubble.
4. $0 destination: ex load rd=0 and ID rs=0 -> id_stall=0, no bubble.
5. flush+hz: ex load rd=4, ID rs=4, flush=1 -> id_stall=0 and the next-cycle EX slot is a bubble. freeze held 3 cycles -> ex_* unchanged for all 3 cycles.
6. ID_EX_PERF_EN: 3 load-use events, 1 flush and 2 freeze cycles -> bubble_cnt=3. Preload at all-ones plus one more event -> stays at all-ones.
